const_hist_corr: RTL and testbench
==================================

CONST_HIST_CORR -- requirements
Module: const_hist_corr

Interface
REQ-001 Parameter NCH, default 2: number of I/Q channels, >=2; channel 0 is the reference.
REQ-002 Parameter IW, default 4: sample width, signed two's complement.
REQ-003 Parameter GL2, default 3: log2 of bins per axis; GRID=2^GL2, with GL2<=IW.
REQ-004 Parameter CW, default 8: bin counter width.
REQ-005 Parameter WIN, default 64: samples per accumulation window, >=1.
REQ-006 Derived widths:
- SW = 2*CW + 2*GL2 + clog2(NCH).
- WCW = clog2(WIN+1).
REQ-007 clk  in  1  single clock; all state updates on its rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 in_valid  in  1  sample vector valid.
REQ-010 in_ready  out  1  block accepts a sample vector.
REQ-011 in_i  in  NCH*IW  I samples; channel c occupies bits [c*IW +: IW].
REQ-012 in_q  in  NCH*IW  Q samples; same packing as in_i.
REQ-013 restart  in  1  synchronous abort-and-clear request.
REQ-014 out_valid  out  1  score available.
REQ-015 out_ready  in  1  consumer accepts score.
REQ-016 out_score  out  SW  correlation score.
REQ-017 out_sat  out  1  a bin counter saturated during the window.

Function
REQ-018 A sample is accepted when in_valid && in_ready are both high.
REQ-019 Bin index per axis: invert the sample MSB (offset binary), then take the top GL2 bits; bin k = qbin*GRID + ibin.
REQ-020 On each accepted sample, every channel increments its own bin k by 1 in the same cycle.
REQ-021 Bin counters saturate at 2^CW-1; any increment attempted on a saturated counter sets out_sat for the current window.
REQ-022 FSM states and transitions:
- ACC: in_ready=1.
- CMP: in_ready=0, out_valid=0.
- OUT: in_ready=0, out_valid=1.
- ACC -> CMP on the accepted sample that makes the window sample count equal WIN.
REQ-023 CMP lasts exactly GRID*GRID cycles; bin k=0..GRID^2-1 is processed in ascending order, one bin per cycle.
- Each cycle adds, for c=1..NCH-1, the product hist0[k]*histc[k] to a full-width SW accumulator; there is no truncation.
- CMP -> OUT after the last bin.
REQ-024 Latency: if the last window sample is accepted in cycle t, out_valid is first high in cycle t+GRID^2+1.
REQ-025 In OUT, out_score and out_sat are held stable until out_ready is high; that handshake cycle clears all histograms, the accumulator, the sample count and out_sat, and returns the FSM to ACC.
REQ-026 When out_valid=0, out_score is 0 and out_sat is 0.
REQ-027 restart in any state clears everything and returns the FSM to ACC on the next cycle; no score is produced.
- restart has priority over a sample accept and over an output handshake in the same cycle.
REQ-028 in_valid is ignored outside ACC; samples presented while in_ready=0 are not counted.

Reset
REQ-029 While rst_n=0, the block is asynchronously held in this state:
- FSM in ACC; in_ready=1.
- out_valid=0, out_score=0, out_sat=0.
- All bin counters, the sample count and the accumulator at 0.
REQ-030 Reset asserted mid-CMP or mid-OUT discards the window; after release, the block behaves as after power-up.

Structure
REQ-031 Package const_hist_pkg holds:
- The FSM state enum (ACC, CMP, OUT).
- Functions bin_index(sample, IW, GL2) and the SW/WCW width computations.
REQ-032 One sub-module, hist_bank, holds one channel's GRID^2 saturating counters, with:
- An increment port.
- A read port at index k.
- A sat flag.
- A clear input.
The top instantiates NCH copies of hist_bank, plus the FSM and the MAC datapath.

Verification
REQ-033 Defaults, 64 samples with every I=Q=0 on both channels: bin (4,4) = 64 on each channel; out_valid rises exactly 65 cycles after the last accept; out_score=4096; out_sat=0.
REQ-034 Defaults, 64 samples with ch0 I=Q=0 and ch1 I=Q=-8: out_score=0.
REQ-035 WIN=300, all samples zero on both channels: counters stop at 255; out_score=65025; out_sat=1.
REQ-036 Score pending with out_ready held low for 10 cycles:
- out_valid and out_score stay stable and in_ready=0 throughout.
- On the handshake, the next window starts from cleared histograms.
REQ-037 restart or rst_n pulsed in the 10th CMP cycle: no out_valid is produced; a following clean 64-sample window yields the correct score with no residue.
REQ-038 in_valid toggling randomly: only accepted samples are counted; a random-stimulus score matches a reference-model histogram dot product.

Source files
------------

// File: rtl/const_hist_pkg.sv
// Shared types and width helpers for the constellation-histogram correlator.
package const_hist_pkg;

  typedef enum logic [1:0] {ACC, CMP, OUT} state_e;

  function automatic int unsigned sw_width(int unsigned nch, int unsigned cw, int unsigned gl2);
    return 2 * cw + 2 * gl2 + $clog2(nch);
  endfunction

  function automatic int unsigned wcw_width(int unsigned win);
    return $clog2(win + 1);
  endfunction

  // Offset-binary conversion (MSB flip) followed by keeping the top gl2 bits.
  function automatic int unsigned bin_index(logic [31:0] sample, int unsigned iw,
                                            int unsigned gl2);
    logic [31:0] ob;
    ob = sample ^ (32'd1 << (iw - 1));
    return (ob >> (iw - gl2)) & ((32'd1 << gl2) - 32'd1);
  endfunction

endpackage

// File: rtl/hist_bank.sv
// One channel's bank of saturating bin counters with a combinational read port.
module hist_bank #(
  parameter int unsigned NBIN = 64,
  parameter int unsigned CW   = 8,
  parameter int unsigned KW   = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  logic [KW-1:0] inc_idx,
  input  logic [KW-1:0] rd_idx,
  output logic [CW-1:0] rd_data,
  output logic          sat
);

  logic [CW-1:0] r_cnt [NBIN];
  logic          r_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < NBIN; b++) r_cnt[b] <= '0;
      r_sat <= 1'b0;
    end else if (clr) begin
      for (int unsigned b = 0; b < NBIN; b++) r_cnt[b] <= '0;
      r_sat <= 1'b0;
    end else if (inc) begin
      // A bump on a full counter leaves it pinned and flags the window.
      if (r_cnt[inc_idx] == '1) r_sat <= 1'b1;
      else                      r_cnt[inc_idx] <= r_cnt[inc_idx] + 1'b1;
    end
  end

  assign rd_data = r_cnt[rd_idx];
  assign sat     = r_sat;

endmodule

// File: rtl/const_hist_corr.sv
// Builds per-channel I/Q constellation histograms over a window and scores each
// channel against channel 0 by a full-precision histogram dot product.
module const_hist_corr
  import const_hist_pkg::*;
#(
  parameter int unsigned NCH = 2,
  parameter int unsigned IW  = 4,
  parameter int unsigned GL2 = 3,
  parameter int unsigned CW  = 8,
  parameter int unsigned WIN = 64
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [NCH*IW-1:0]                     in_i,
  input  logic [NCH*IW-1:0]                     in_q,
  input  logic                                  restart,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [sw_width(NCH, CW, GL2)-1:0]     out_score,
  output logic                                  out_sat
);

  localparam int unsigned GRID = 1 << GL2;
  localparam int unsigned NBIN = GRID * GRID;
  localparam int unsigned KW   = 2 * GL2;
  localparam int unsigned SW   = sw_width(NCH, CW, GL2);
  localparam int unsigned WCW  = wcw_width(WIN);

  state_e         r_state;
  logic [WCW-1:0] r_cnt;
  logic [KW-1:0]  r_k;
  logic [SW-1:0]  r_acc;

  logic           w_accept;
  logic           w_clr;
  logic [KW-1:0]  w_idx [NCH];
  logic [CW-1:0]  w_rd  [NCH];
  logic [NCH-1:0] w_sat;
  logic [SW-1:0]  w_mac;

  assign w_accept = in_valid && (r_state == ACC);
  assign w_clr    = restart || ((r_state == OUT) && out_ready);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [GL2-1:0] w_ibin;
    logic [GL2-1:0] w_qbin;

    assign w_ibin   = GL2'(bin_index(32'(in_i[c*IW +: IW]), IW, GL2));
    assign w_qbin   = GL2'(bin_index(32'(in_q[c*IW +: IW]), IW, GL2));
    assign w_idx[c] = {w_qbin, w_ibin};

    hist_bank #(
      .NBIN (NBIN),
      .CW   (CW),
      .KW   (KW)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (w_clr),
      .inc     (w_accept),
      .inc_idx (w_idx[c]),
      .rd_idx  (r_k),
      .rd_data (w_rd[c]),
      .sat     (w_sat[c])
    );
  end

  always_comb begin
    w_mac = '0;
    for (int unsigned c = 1; c < NCH; c++) begin
      w_mac = w_mac + SW'(w_rd[0]) * SW'(w_rd[c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACC;
      r_cnt   <= '0;
      r_k     <= '0;
      r_acc   <= '0;
    end else if (restart) begin
      r_state <= ACC;
      r_cnt   <= '0;
      r_k     <= '0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        ACC: begin
          if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == WCW'(WIN - 1)) begin
              r_state <= CMP;
              r_k     <= '0;
            end
          end
        end
        CMP: begin
          r_acc <= r_acc + w_mac;
          r_k   <= r_k + 1'b1;
          if (r_k == KW'(NBIN - 1)) r_state <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            r_state <= ACC;
            r_cnt   <= '0;
            r_k     <= '0;
            r_acc   <= '0;
          end
        end
        default: r_state <= ACC;
      endcase
    end
  end

  assign in_ready  = (r_state == ACC);
  assign out_valid = (r_state == OUT);
  assign out_score = out_valid ? r_acc : '0;
  assign out_sat   = out_valid && (|w_sat);

endmodule

// File: tb/tb_const_hist_corr.sv
// Directed and lightly randomised checks of const_hist_corr at default parameters,
// plus a WIN=300 instance for counter saturation.
module tb_const_hist_corr;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, restart, out_ready;
  logic [7:0]  in_i, in_q;
  logic        in_ready, out_valid, out_sat;
  logic [22:0] out_score;

  logic        b_in_valid, b_restart, b_out_ready;
  logic [7:0]  b_in_i, b_in_q;
  logic        b_in_ready, b_out_valid, b_out_sat;
  logic [22:0] b_out_score;

  int n_checks = 0;
  int n_fail   = 0;

  const_hist_corr dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_i      (in_i),
    .in_q      (in_q),
    .restart   (restart),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_score (out_score),
    .out_sat   (out_sat)
  );

  const_hist_corr #(.WIN(300)) dut_w300 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_i      (b_in_i),
    .in_q      (b_in_q),
    .restart   (b_restart),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_score (b_out_score),
    .out_sat   (b_out_sat)
  );

  task automatic feed(input logic [3:0] i0, input logic [3:0] q0, input logic [3:0] i1,
                      input logic [3:0] q1, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_i     = {i1, i0};
      in_q     = {q1, q0};
    end
  endtask

  // Counts negedges after the last accept until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    while (lat < 300) begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic handshake;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; restart = 1'b0; out_ready = 1'b0; in_i = '0; in_q = '0;
    b_in_valid = 1'b0; b_restart = 1'b0; b_out_ready = 1'b0; b_in_i = '0; b_in_q = '0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++;
    if (out_score !== 23'd0) begin n_fail++; $display("FAIL reset_score got %0d want 0", out_score); end
    n_checks++;
    if (out_sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat got %b want 0", out_sat); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got %b want 1", in_ready); end
  endtask

  task automatic test_zero;
    int lat;
    feed(4'h0, 4'h0, 4'h0, 4'h0, 64);
    wait_out(lat);
    n_checks++;
    if (lat !== 65) begin n_fail++; $display("FAIL zero_latency got %0d want 65", lat); end
    n_checks++;
    if (out_score !== 23'd4096) begin n_fail++; $display("FAIL zero_score got %0d want 4096", out_score); end
    n_checks++;
    if (out_sat !== 1'b0) begin n_fail++; $display("FAIL zero_sat got %b want 0", out_sat); end
    handshake();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_score !== 23'd0) begin
      n_fail++;
      $display("FAIL zero_after_hs got valid=%b ready=%b score=%0d want 0 1 0",
               out_valid, in_ready, out_score);
    end
  endtask

  task automatic test_orth;
    int lat;
    feed(4'h0, 4'h0, 4'h8, 4'h8, 64);
    wait_out(lat);
    n_checks++;
    if (lat !== 65) begin n_fail++; $display("FAIL orth_latency got %0d want 65", lat); end
    n_checks++;
    if (out_score !== 23'd0) begin n_fail++; $display("FAIL orth_score got %0d want 0", out_score); end
    handshake();
  endtask

  task automatic test_backpressure;
    int lat;
    int bad;
    feed(4'h0, 4'h0, 4'h0, 4'h0, 32);
    feed(4'h7, 4'h7, 4'h7, 4'h7, 32);
    wait_out(lat);
    n_checks++;
    if (lat !== 65) begin n_fail++; $display("FAIL bp_latency got %0d want 65", lat); end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      // Samples offered while stalled must not be counted.
      in_valid = 1'b1; in_i = 8'h00; in_q = 8'h00;
      @(negedge clk);
      if (out_valid !== 1'b1 || out_score !== 23'd2048 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cycle %0d got valid=%b score=%0d ready=%b want 1 2048 0",
                 k, out_valid, out_score, in_ready);
      end
      n_checks++;
    end
    n_fail += bad;
    handshake();
    feed(4'h7, 4'h7, 4'h0, 4'h0, 64);
    wait_out(lat);
    n_checks++;
    if (out_score !== 23'd0) begin n_fail++; $display("FAIL bp_next_window got %0d want 0", out_score); end
    handshake();
  endtask

  task automatic test_restart;
    int lat;
    int seen;
    feed(4'h0, 4'h0, 4'h0, 4'h0, 64);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_state got ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
    seen = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL restart_no_output got %0d valid cycles want 0", seen); end
    feed(4'h0, 4'h0, 4'h0, 4'h0, 64);
    wait_out(lat);
    n_checks++;
    if (lat !== 65 || out_score !== 23'd4096) begin
      n_fail++;
      $display("FAIL restart_clean got lat=%0d score=%0d want 65 4096", lat, out_score);
    end
    handshake();
  endtask

  task automatic test_rst_mid;
    int lat;
    int seen;
    feed(4'h0, 4'h0, 4'h0, 4'h0, 64);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_state got ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL rst_mid_no_output got %0d want 0", seen); end
    feed(4'h0, 4'h0, 4'h0, 4'h0, 64);
    wait_out(lat);
    n_checks++;
    if (lat !== 65 || out_score !== 23'd4096) begin
      n_fail++;
      $display("FAIL rst_mid_clean got lat=%0d score=%0d want 65 4096", lat, out_score);
    end
    handshake();
  endtask

  task automatic test_sat;
    int lat;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      b_in_valid = 1'b1;
    end
    lat = 0;
    while (lat < 300) begin
      @(negedge clk);
      b_in_valid = 1'b0;
      lat++;
      if (b_out_valid) break;
    end
    n_checks++;
    if (lat !== 65) begin n_fail++; $display("FAIL sat_latency got %0d want 65", lat); end
    n_checks++;
    if (b_out_score !== 23'd65025) begin
      n_fail++;
      $display("FAIL sat_score got %0d want 65025", b_out_score);
    end
    n_checks++;
    if (b_out_sat !== 1'b1) begin n_fail++; $display("FAIL sat_flag got %b want 1", b_out_sat); end
    @(negedge clk);
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    n_checks++;
    if (b_out_sat !== 1'b0 || b_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_cleared got sat=%b valid=%b want 0 0", b_out_sat, b_out_valid);
    end
  endtask

  task automatic test_random;
    int h0 [64];
    int h1 [64];
    int acc_n;
    int iter;
    int lat;
    int exp_score;
    logic [3:0] s [4];
    int b [4];
    for (int k = 0; k < 64; k++) begin h0[k] = 0; h1[k] = 0; end
    acc_n = 0;
    iter  = 0;
    while (acc_n < 64 && iter < 1000) begin
      @(negedge clk);
      iter++;
      for (int j = 0; j < 4; j++) begin
        s[j] = 4'($urandom_range(15));
        b[j] = (int'($signed(s[j])) + 8) / 2;
      end
      in_valid = 1'($urandom_range(1));
      in_i = {s[1], s[0]};
      in_q = {s[3], s[2]};
      if (in_valid && in_ready) begin
        h0[b[2] * 8 + b[0]]++;
        h1[b[3] * 8 + b[1]]++;
        acc_n++;
      end
    end
    exp_score = 0;
    for (int k = 0; k < 64; k++) exp_score += h0[k] * h1[k];
    wait_out(lat);
    n_checks++;
    if (lat !== 65) begin n_fail++; $display("FAIL rand_latency got %0d want 65", lat); end
    n_checks++;
    if (int'(out_score) !== exp_score) begin
      n_fail++;
      $display("FAIL rand_score got %0d want %0d", out_score, exp_score);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_zero();
    test_orth();
    test_backpressure();
    test_restart();
    test_rst_mid();
    test_sat();
    test_random();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
